uv_rom_arb: RTL and testbench

UV_ROM_ARB -- requirements
Module: uv_rom_arb

---
 rtl/uv_rom_arb.sv | 179 +++++++++++++++++
 tb/tb_uv_rom_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uv_rom_arb.sv
// uv_rom_arb: two-master round-robin arbiter in front of a read-only memory.
// Master reads are forwarded to the ROM with zero latency.
// Master writes are absorbed locally and answered with an error response.
// Only one transaction is outstanding at a time.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   mst_req_*       per-master request channel (slice i = master i)
//   mst_rsp_*       per-master response channel (2-bit excp per master)
//   rom_req_*       request channel towards the ROM
//   rom_rsp_*       response channel from the ROM
module uv_rom_arb #(
  parameter int ALEN = 26,
  parameter int DLEN = 32,
  parameter int MLEN = DLEN / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mst_req_vld,
  output logic [1:0]        mst_req_rdy,
  input  logic [1:0]        mst_req_read,
  input  logic [2*ALEN-1:0] mst_req_addr,
  input  logic [2*MLEN-1:0] mst_req_mask,
  input  logic [2*DLEN-1:0] mst_req_data,
  output logic [1:0]        mst_rsp_vld,
  input  logic [1:0]        mst_rsp_rdy,
  output logic [3:0]        mst_rsp_excp,
  output logic [2*DLEN-1:0] mst_rsp_data,
  output logic              rom_req_vld,
  input  logic              rom_req_rdy,
  output logic              rom_req_read,
  output logic [ALEN-1:0]   rom_req_addr,
  output logic [MLEN-1:0]   rom_req_mask,
  output logic [DLEN-1:0]   rom_req_data,
  input  logic              rom_rsp_vld,
  output logic              rom_rsp_rdy,
  input  logic [1:0]        rom_rsp_excp,
  input  logic [DLEN-1:0]   rom_rsp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t state_r;
  logic   ptr_r;        // preferred master when both request
  logic   owner_r;      // master that owns the outstanding transaction
  logic   lock_vld_r;   // a read was offered to the ROM but not taken
  logic   lock_idx_r;   // master that read was offered for

  logic   any_s;
  logic   grant_s;
  logic   grant_read_s;
  logic   accept_s;
  logic            own_vld_s;
  logic [1:0]      own_excp_s;
  logic [DLEN-1:0] own_data_s;

  // Grant selection: a stalled read keeps its grant so the ROM sees a stable
  // request; otherwise round-robin on the pointer, or the sole requester.
  always_comb begin
    any_s = |mst_req_vld;
    if (lock_vld_r && mst_req_vld[lock_idx_r]) begin
      grant_s = lock_idx_r;
    end else if (mst_req_vld == 2'b11) begin
      grant_s = ptr_r;
    end else if (mst_req_vld[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    grant_read_s = mst_req_read[grant_s];
  end

  // Request path: reads are forwarded to the ROM, writes are accepted locally.
  always_comb begin
    mst_req_rdy  = 2'b00;
    rom_req_vld  = 1'b0;
    accept_s     = 1'b0;
    rom_req_read = grant_read_s;
    rom_req_addr = grant_s ? mst_req_addr[2*ALEN-1:ALEN] : mst_req_addr[ALEN-1:0];
    rom_req_mask = grant_s ? mst_req_mask[2*MLEN-1:MLEN] : mst_req_mask[MLEN-1:0];
    rom_req_data = grant_s ? mst_req_data[2*DLEN-1:DLEN] : mst_req_data[DLEN-1:0];
    if (rst_n && (state_r == IDLE) && any_s) begin
      if (grant_read_s) begin
        rom_req_vld          = 1'b1;
        mst_req_rdy[grant_s] = rom_req_rdy;
        accept_s             = rom_req_rdy;
      end else begin
        mst_req_rdy[grant_s] = 1'b1;
        accept_s             = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Owner-side response: ROM pass-through in WAIT, local error in ERR.
  always_comb begin
    own_vld_s   = 1'b0;
    own_excp_s  = 2'b00;
    own_data_s  = {DLEN{1'b0}};
    rom_rsp_rdy = 1'b0;
    if (rst_n) begin
      case (state_r)
        WAIT: begin
          own_vld_s   = rom_rsp_vld;
          own_excp_s  = rom_rsp_excp;
          own_data_s  = rom_rsp_data;
          rom_rsp_rdy = mst_rsp_rdy[owner_r];
        end
        ERR: begin
          own_vld_s  = 1'b1;
          own_excp_s = 2'b01;
        end
        default: begin
          own_vld_s = 1'b0;
        end
      endcase
    end else begin
      own_vld_s = 1'b0;
    end
  end

  // Route the owner-side response onto the owner's slice; the other slice stays 0.
  always_comb begin
    if (owner_r) begin
      mst_rsp_vld  = {own_vld_s, 1'b0};
      mst_rsp_excp = {own_excp_s, 2'b00};
      mst_rsp_data = {own_data_s, {DLEN{1'b0}}};
    end else begin
      mst_rsp_vld  = {1'b0, own_vld_s};
      mst_rsp_excp = {2'b00, own_excp_s};
      mst_rsp_data = {{DLEN{1'b0}}, own_data_s};
    end
  end

  // Transaction FSM, round-robin pointer, owner and grant lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= 1'b0;
      owner_r    <= 1'b0;
      lock_vld_r <= 1'b0;
      lock_idx_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          lock_vld_r <= rom_req_vld & ~rom_req_rdy;
          lock_idx_r <= grant_s;
          if (accept_s) begin
            ptr_r   <= ~grant_s;
            owner_r <= grant_s;
            state_r <= grant_read_s ? WAIT : ERR;
          end
        end
        WAIT: begin
          lock_vld_r <= 1'b0;
          if (rom_rsp_vld && mst_rsp_rdy[owner_r]) begin
            state_r <= IDLE;
          end
        end
        ERR: begin
          lock_vld_r <= 1'b0;
          if (mst_rsp_rdy[owner_r]) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          lock_vld_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uv_rom_arb.sv
// tb_uv_rom_arb: directed scenarios followed by random traffic, every cycle
// checked against a transaction-level reference model of the arbiter.
module tb_uv_rom_arb;
  localparam int ALEN = 26;
  localparam int DLEN = 32;
  localparam int MLEN = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mst_req_vld, mst_req_rdy, mst_req_read;
  logic [2*ALEN-1:0] mst_req_addr;
  logic [2*MLEN-1:0] mst_req_mask;
  logic [2*DLEN-1:0] mst_req_data;
  logic [1:0]        mst_rsp_vld, mst_rsp_rdy;
  logic [3:0]        mst_rsp_excp;
  logic [2*DLEN-1:0] mst_rsp_data;
  logic              rom_req_vld, rom_req_rdy, rom_req_read;
  logic [ALEN-1:0]   rom_req_addr;
  logic [MLEN-1:0]   rom_req_mask;
  logic [DLEN-1:0]   rom_req_data;
  logic              rom_rsp_vld, rom_rsp_rdy;
  logic [1:0]        rom_rsp_excp;
  logic [DLEN-1:0]   rom_rsp_data;

  uv_rom_arb #(.ALEN(ALEN), .DLEN(DLEN), .MLEN(MLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .mst_req_vld(mst_req_vld), .mst_req_rdy(mst_req_rdy), .mst_req_read(mst_req_read),
    .mst_req_addr(mst_req_addr), .mst_req_mask(mst_req_mask), .mst_req_data(mst_req_data),
    .mst_rsp_vld(mst_rsp_vld), .mst_rsp_rdy(mst_rsp_rdy), .mst_rsp_excp(mst_rsp_excp),
    .mst_rsp_data(mst_rsp_data),
    .rom_req_vld(rom_req_vld), .rom_req_rdy(rom_req_rdy), .rom_req_read(rom_req_read),
    .rom_req_addr(rom_req_addr), .rom_req_mask(rom_req_mask), .rom_req_data(rom_req_data),
    .rom_rsp_vld(rom_rsp_vld), .rom_rsp_rdy(rom_rsp_rdy), .rom_rsp_excp(rom_rsp_excp),
    .rom_rsp_data(rom_rsp_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what is outstanding (0 none, 1 ROM read, 2 local error),
  // who owns it, the round-robin preference and a stalled-read grant.
  int m_busy;
  bit m_ptr, m_owner, m_lock_vld, m_lock_idx;

  // Snapshot of DUT outputs at the latest check point.
  logic [1:0]      s_req_rdy, s_rsp_vld;
  logic            s_rom_vld, s_rsp_rdy;
  logic [ALEN-1:0] s_addr;
  logic [3:0]      s_excp;
  logic [2*DLEN-1:0] s_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input bit v, input bit rd, input logic [ALEN-1:0] a);
    mst_req_vld[i]  = v;
    mst_req_read[i] = rd;
    mst_req_addr[i*ALEN +: ALEN] = a;
    mst_req_mask[i*MLEN +: MLEN] = MLEN'($urandom);
    mst_req_data[i*DLEN +: DLEN] = $urandom;
  endtask

  // One cycle: let inputs settle, compare every output with the model,
  // advance the model as the coming clock edge will, move to the next negedge.
  task automatic step();
    logic [1:0] e_req_rdy, e_rsp_vld;
    logic e_rom_vld, e_rsp_rdy;
    logic [3:0] e_excp;
    logic [2*DLEN-1:0] e_data;
    int g;
    bit acc, rd;
    #1;
    s_req_rdy = mst_req_rdy; s_rsp_vld = mst_rsp_vld; s_rom_vld = rom_req_vld;
    s_rsp_rdy = rom_rsp_rdy; s_addr = rom_req_addr; s_excp = mst_rsp_excp; s_data = mst_rsp_data;
    e_req_rdy = 2'b00; e_rsp_vld = 2'b00; e_rom_vld = 1'b0; e_rsp_rdy = 1'b0;
    e_excp = 4'b0000; e_data = '0; g = 0; acc = 1'b0; rd = 1'b0;
    if (rst_n) begin
      if (m_busy == 0 && mst_req_vld != 2'b00) begin
        if (m_lock_vld && mst_req_vld[m_lock_idx]) g = int'(m_lock_idx);
        else if (mst_req_vld == 2'b11) g = int'(m_ptr);
        else g = mst_req_vld[1] ? 1 : 0;
        rd = mst_req_read[g];
        if (rd) begin
          e_rom_vld = 1'b1; e_req_rdy[g] = rom_req_rdy; acc = rom_req_rdy;
        end else begin
          e_req_rdy[g] = 1'b1; acc = 1'b1;
        end
      end else if (m_busy == 1) begin
        e_rsp_vld[m_owner] = rom_rsp_vld;
        e_excp[m_owner*2 +: 2] = rom_rsp_excp;
        e_data[m_owner*DLEN +: DLEN] = rom_rsp_data;
        e_rsp_rdy = mst_rsp_rdy[m_owner];
      end else if (m_busy == 2) begin
        e_rsp_vld[m_owner] = 1'b1;
        e_excp[m_owner*2 +: 2] = 2'b01;
      end
    end
    chk("mst_req_rdy", 64'(s_req_rdy), 64'(e_req_rdy));
    chk("rom_req_vld", 64'(s_rom_vld), 64'(e_rom_vld));
    chk("mst_rsp_vld", 64'(s_rsp_vld), 64'(e_rsp_vld));
    chk("mst_rsp_excp", 64'(s_excp), 64'(e_excp));
    chk("mst_rsp_data", s_data, e_data);
    chk("rom_rsp_rdy", 64'(s_rsp_rdy), 64'(e_rsp_rdy));
    if (e_rom_vld) begin
      chk("rom_req_addr", 64'(rom_req_addr), 64'(mst_req_addr[g*ALEN +: ALEN]));
      chk("rom_req_mask", 64'(rom_req_mask), 64'(mst_req_mask[g*MLEN +: MLEN]));
      chk("rom_req_data", 64'(rom_req_data), 64'(mst_req_data[g*DLEN +: DLEN]));
      chk("rom_req_read", 64'(rom_req_read), 64'(1'b1));
    end
    if (!rst_n) begin
      m_busy = 0; m_ptr = 1'b0; m_owner = 1'b0; m_lock_vld = 1'b0; m_lock_idx = 1'b0;
    end else if (m_busy == 0) begin
      m_lock_vld = e_rom_vld && !rom_req_rdy;
      m_lock_idx = (g == 1);
      if (acc) begin
        m_ptr = (g == 0); m_owner = (g == 1); m_busy = rd ? 1 : 2;
      end
    end else begin
      m_lock_vld = 1'b0;
      if (m_busy == 1 && rom_rsp_vld && mst_rsp_rdy[m_owner]) m_busy = 0;
      else if (m_busy == 2 && mst_rsp_rdy[m_owner]) m_busy = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; mst_req_vld = 2'b00; mst_req_read = 2'b00; mst_req_addr = '0;
    mst_req_mask = '0; mst_req_data = '0; mst_rsp_rdy = 2'b11; rom_req_rdy = 1'b1;
    rom_rsp_vld = 1'b0; rom_rsp_excp = 2'b00; rom_rsp_data = '0;
    m_busy = 0; m_ptr = 1'b0; m_owner = 1'b0; m_lock_vld = 1'b0; m_lock_idx = 1'b0;
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;

    // Both masters read: 0x100 to master 0 first, then 0x200 to master 1.
    set_m(0, 1'b1, 1'b1, 26'h100); set_m(1, 1'b1, 1'b1, 26'h200);
    step();
    chk("s1_addr0", 64'(s_addr), 64'h100);
    chk("s1_grant0", 64'(s_req_rdy), 64'h1);
    mst_req_vld[0] = 1'b0; rom_rsp_vld = 1'b1; rom_rsp_data = 32'h1234_5678;
    step();
    chk("s1_rsp_m0", 64'(s_rsp_vld), 64'h1);
    chk("s1_data_m0", s_data, 64'h0000_0000_1234_5678);
    rom_rsp_vld = 1'b0;
    step();
    chk("s1_addr1", 64'(s_addr), 64'h200);
    chk("s1_grant1", 64'(s_req_rdy), 64'h2);
    mst_req_vld = 2'b00; rom_rsp_vld = 1'b1; rom_rsp_data = 32'h9abc_def0;
    step();
    chk("s1_rsp_m1", 64'(s_rsp_vld), 64'h2);
    chk("s1_data_m1", s_data, 64'h9abc_def0_0000_0000);
    rom_rsp_vld = 1'b0;
    step();

    // Master 1 write: local error response held while rsp_rdy is low.
    set_m(1, 1'b1, 1'b0, 26'h3ff); mst_rsp_rdy = 2'b00;
    step();
    chk("s2_rom_vld", 64'(s_rom_vld), 64'h0);
    chk("s2_wr_rdy", 64'(s_req_rdy), 64'h2);
    mst_req_vld = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s2_err_vld", 64'(s_rsp_vld), 64'h2);
      chk("s2_err_excp", 64'(s_excp), 64'h4);
      chk("s2_err_data", s_data, 64'h0);
    end
    mst_rsp_rdy = 2'b11;
    step();
    chk("s2_err_done", 64'(s_rsp_vld), 64'h2);
    step();

    // ROM stalls a read from master 0 for 4 cycles.
    set_m(0, 1'b1, 1'b1, 26'habc); rom_req_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s3_stall_rdy", 64'(s_req_rdy), 64'h0);
      chk("s3_stall_vld", 64'(s_rom_vld), 64'h1);
      chk("s3_stall_addr", 64'(s_addr), 64'habc);
    end
    rom_req_rdy = 1'b1;
    step();
    chk("s3_accept", 64'(s_req_rdy), 64'h1);

    // Master 0 holds off its response; master 1 must wait.
    mst_req_vld[0] = 1'b0; set_m(1, 1'b1, 1'b1, 26'h300);
    mst_rsp_rdy = 2'b10; rom_rsp_vld = 1'b1; rom_rsp_data = 32'h5555_aaaa;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s4_rsp_rdy", 64'(s_rsp_rdy), 64'h0);
      chk("s4_no_grant", 64'(s_req_rdy), 64'h0);
    end
    mst_rsp_rdy = 2'b11;
    step();
    chk("s4_rsp_hs", 64'(s_rsp_rdy), 64'h1);
    rom_rsp_vld = 1'b0;
    step();
    chk("s4_grant1", 64'(s_req_rdy), 64'h2);
    mst_req_vld = 2'b00; rom_rsp_vld = 1'b1;
    step();
    rom_rsp_vld = 1'b0;
    step();

    // Both masters continuously reading: grants alternate 0,1,0,1,...
    set_m(0, 1'b1, 1'b1, 26'h10); set_m(1, 1'b1, 1'b1, 26'h20);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("s5_grant", 64'(s_req_rdy), (k % 2 == 0) ? 64'h1 : 64'h2);
      rom_rsp_vld = 1'b1;
      step();
      rom_rsp_vld = 1'b0;
    end
    mst_req_vld = 2'b00;
    step();

    // Reset during WAIT drops the transaction and clears the pointer.
    set_m(0, 1'b1, 1'b1, 26'h40);
    step();
    mst_req_vld = 2'b00; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("s6_rsp_vld", 64'(s_rsp_vld), 64'h0);
    chk("s6_rom_vld", 64'(s_rom_vld), 64'h0);
    mst_req_vld = 2'b11; mst_req_read = 2'b11;
    step();
    chk("s6_ptr0", 64'(s_req_rdy), 64'h1);
    mst_req_vld = 2'b00; rom_rsp_vld = 1'b1;
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < 2; i++) begin
        set_m(i, 1'($urandom), ($urandom_range(0, 3) != 0), ALEN'($urandom));
      end
      mst_rsp_rdy  = 2'($urandom);
      rom_req_rdy  = 1'($urandom);
      rom_rsp_vld  = 1'($urandom);
      rom_rsp_excp = 2'($urandom);
      rom_rsp_data = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
